time_of_day_counter: RTL and testbench

- Consumer end of the divided clock: samples the slow 1 Hz square wave from the clock divider in the main clock domain and synchronises it.
- Turns each rising edge into a single-cycle tick and keeps a BCD hh:mm:ss time-of-day for the alarm comparator and display mux.
- Supports a req/ack time-set handshake from the button/menu logic.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/time_of_day_counter_if.sv | 22 ++
 rtl/time_of_day_counter_sync.sv | 32 +++
 rtl/time_of_day_counter.sv | 155 +++++++++++++++
 tb/tb_time_of_day_counter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day block: BCD digit limits and the
// state encoding of the time-set handshake.
package clock_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    typedef logic [2*DIGIT_W-1:0] bcd2_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACK,
        WAIT_DROP
    } set_state_t;

    // True when both digits are decimal and the tens digit is within tens_max.
    function automatic logic bcd_digits_ok(input bcd2_t v, input logic [DIGIT_W-1:0] tens_max);
        return (v[2*DIGIT_W-1:DIGIT_W] <= tens_max) && (v[DIGIT_W-1:0] <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Time-set request/acknowledge bundle between the menu logic (master) and
// the time-of-day counter (slave).
interface time_of_day_counter_if import clock_pkg::*; ();

    logic  set_req;
    bcd2_t set_hh;
    bcd2_t set_mm;
    bcd2_t set_ss;
    logic  set_ack;
    logic  set_err;

    modport master (
        output set_req, set_hh, set_mm, set_ss,
        input  set_ack, set_err
    );

    modport slave (
        input  set_req, set_hh, set_mm, set_ss,
        output set_ack, set_err
    );

endinterface

// File: rtl/time_of_day_counter_sync.sv
// Synchroniser plus rising-edge detector for a slow asynchronous strobe;
// produces a single-cycle tick in the clk domain.
module tick_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   hist_p;
    logic [SYNC_STAGES:0]   vld_p;

    // vld_p marks which flops hold real samples; the edge is only trusted once
    // the history flop does, so a strobe already high at reset release is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p <= '0;
            hist_p <= 1'b0;
            vld_p  <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
            hist_p <= sync_p[SYNC_STAGES-1];
            vld_p  <= {vld_p[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign tick = sync_p[SYNC_STAGES-1] & ~hist_p & vld_p[SYNC_STAGES];

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by the synchronised 1 Hz strobe,
// with a req/ack handshake to load a new time.
module time_of_day_counter import clock_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_LIMIT  = 23
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_in,
    time_of_day_counter_if.slave        set_if,
    output bcd2_t                       hh,
    output bcd2_t                       mm,
    output bcd2_t                       ss,
    output logic                        sec_pulse,
    output logic                        min_pulse,
    output logic                        day_wrap
);

    localparam bcd2_t HH_LIMIT = {4'(HOUR_LIMIT / 10), 4'(HOUR_LIMIT % 10)};

    // Low 8 bits: next value; bit 8: the pair wrapped to 00.
    function automatic logic [8:0] bcd_step(input bcd2_t v, input logic [DIGIT_W-1:0] tens_max);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = v[2*DIGIT_W-1:DIGIT_W];
        ones = v[DIGIT_W-1:0];
        if (ones != DIGIT_MAX) return {1'b0, tens, ones + 4'd1};
        if (tens != tens_max)  return {1'b0, tens + 4'd1, 4'd0};
        return {1'b1, 8'h00};
    endfunction

    function automatic logic [8:0] hour_step(input bcd2_t v);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = v[2*DIGIT_W-1:DIGIT_W];
        ones = v[DIGIT_W-1:0];
        if (v == HH_LIMIT)     return {1'b1, 8'h00};
        if (ones != DIGIT_MAX) return {1'b0, tens, ones + 4'd1};
        return {1'b0, tens + 4'd1, 4'd0};
    endfunction

    logic       tick;
    set_state_t state, state_nxt;
    logic       capture_en, load_en, ack_nxt, err_nxt, set_valid;
    bcd2_t      cap_hh, cap_mm, cap_ss;
    bcd2_t      hh_nxt, mm_nxt, ss_nxt;
    logic       sec_nxt, min_nxt, day_nxt;
    logic [8:0] ss_step, mm_step, hh_step;

    tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (tick_in),
        .tick (tick)
    );

    // Captured request values are plain data: only meaningful after capture_en.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            cap_hh <= set_if.set_hh;
            cap_mm <= set_if.set_mm;
            cap_ss <= set_if.set_ss;
        end
    end

    assign set_valid = bcd_digits_ok(cap_ss, SEC_TENS_MAX) &&
                       bcd_digits_ok(cap_mm, SEC_TENS_MAX) &&
                       (cap_hh[DIGIT_W-1:0] <= DIGIT_MAX)  &&
                       (cap_hh <= HH_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            set_if.set_ack <= 1'b0;
            set_if.set_err <= 1'b0;
        end else begin
            state          <= state_nxt;
            set_if.set_ack <= ack_nxt;
            set_if.set_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        capture_en = 1'b0;
        load_en    = 1'b0;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (set_if.set_req) begin
                    state_nxt  = CHECK;
                    capture_en = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = ACK;
                ack_nxt   = 1'b1;
                err_nxt   = ~set_valid;
                load_en   = set_valid;
            end
            ACK:       state_nxt = WAIT_DROP;
            WAIT_DROP: if (!set_if.set_req) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A load takes priority over a coincident tick, which is then lost.
    always_comb begin
        ss_step = bcd_step(ss, SEC_TENS_MAX);
        mm_step = bcd_step(mm, SEC_TENS_MAX);
        hh_step = hour_step(hh);
        hh_nxt  = hh;
        mm_nxt  = mm;
        ss_nxt  = ss;
        sec_nxt = 1'b0;
        min_nxt = 1'b0;
        day_nxt = 1'b0;
        if (load_en) begin
            hh_nxt = cap_hh;
            mm_nxt = cap_mm;
            ss_nxt = cap_ss;
        end else if (tick) begin
            sec_nxt = 1'b1;
            ss_nxt  = ss_step[7:0];
            if (ss_step[8]) begin
                min_nxt = 1'b1;
                mm_nxt  = mm_step[7:0];
                if (mm_step[8]) begin
                    hh_nxt  = hh_step[7:0];
                    day_nxt = hh_step[8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            hh        <= hh_nxt;
            mm        <= mm_nxt;
            ss        <= ss_nxt;
            sec_pulse <= sec_nxt;
            min_pulse <= min_nxt;
            day_wrap  <= day_nxt;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: a 24-hour and a 12-hour build share
// clock, reset, strobe and set values, and are checked against hand-computed results.
module tb_time_of_day_counter;

    logic clk, rst, tick_in;
    logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
    logic sec_a, min_a, day_a, sec_b, min_b, day_b;

    time_of_day_counter_if if_a ();
    time_of_day_counter_if if_b ();

    time_of_day_counter #(.SYNC_STAGES(2), .HOUR_LIMIT(23)) dut_a (
        .clk(clk), .rst(rst), .tick_in(tick_in), .set_if(if_a),
        .hh(hh_a), .mm(mm_a), .ss(ss_a),
        .sec_pulse(sec_a), .min_pulse(min_a), .day_wrap(day_a)
    );

    time_of_day_counter #(.SYNC_STAGES(2), .HOUR_LIMIT(11)) dut_b (
        .clk(clk), .rst(rst), .tick_in(tick_in), .set_if(if_b),
        .hh(hh_b), .mm(mm_b), .ss(ss_b),
        .sec_pulse(sec_b), .min_pulse(min_b), .day_wrap(day_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  h, m, s;
        logic        err_a, err_b;
        logic [23:0] t_a, t_b;
    } set_vec_t;

    set_vec_t vecs [9];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int lat_a;
    int sec_cnt_a, min_cnt_a, day_cnt_a, ack_cnt_a, err_cnt_a, stray_err_a, bad_day_a;
    int sec_cnt_b, min_cnt_b, day_cnt_b, ack_cnt_b, err_cnt_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        lat_a = -1;
        sec_cnt_a = 0; min_cnt_a = 0; day_cnt_a = 0; ack_cnt_a = 0; err_cnt_a = 0;
        stray_err_a = 0; bad_day_a = 0;
        sec_cnt_b = 0; min_cnt_b = 0; day_cnt_b = 0; ack_cnt_b = 0; err_cnt_b = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sec_a) begin
            sec_cnt_a++;
            if (lat_a < 0) lat_a = cyc - rise_cyc;
        end
        if (min_a) min_cnt_a++;
        if (day_a) day_cnt_a++;
        if (day_a && !(sec_a && min_a)) bad_day_a++;
        if (if_a.set_ack) ack_cnt_a++;
        if (if_a.set_ack && if_a.set_err) err_cnt_a++;
        if (!if_a.set_ack && if_a.set_err) stray_err_a++;
        if (sec_b) sec_cnt_b++;
        if (min_b) min_cnt_b++;
        if (day_b) day_cnt_b++;
        if (if_b.set_ack) ack_cnt_b++;
        if (if_b.set_ack && if_b.set_err) err_cnt_b++;
    endtask

    task automatic drive_set(input logic req, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if_a.set_req = req; if_a.set_hh = h; if_a.set_mm = m; if_a.set_ss = s;
        if_b.set_req = req; if_b.set_hh = h; if_b.set_mm = m; if_b.set_ss = s;
    endtask

    task automatic do_tick();
        clear_counts();
        tick_in  = 1'b1;
        rise_cyc = cyc;
        repeat (6) step();
        tick_in = 1'b0;
        repeat (6) step();
    endtask

    // Request held well past the ack so a second load would be visible.
    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        clear_counts();
        drive_set(1'b1, h, m, s);
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_cnt_a > 0) break;
        end
        check("ack_seen", 32'(ack_cnt_a > 0), 32'd1);
        repeat (10) step();
        drive_set(1'b0, h, m, s);
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 24'h235958, 24'h000003};
        vecs[1] = '{8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 24'h123456, 24'h000003};
        vecs[2] = '{8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 24'h115959, 24'h115959};
        vecs[3] = '{8'h24, 8'h00, 8'h00, 1'b1, 1'b1, 24'h115959, 24'h115959};
        vecs[4] = '{8'h00, 8'h6A, 8'h00, 1'b1, 1'b1, 24'h115959, 24'h115959};
        vecs[5] = '{8'h00, 8'h00, 8'h60, 1'b1, 1'b1, 24'h115959, 24'h115959};
        vecs[6] = '{8'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 24'h115959, 24'h115959};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 24'h000000, 24'h000000};
        vecs[8] = '{8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 24'h235958, 24'h000000};

        rst = 1'b1;
        tick_in = 1'b0;
        drive_set(1'b0, 8'h00, 8'h00, 8'h00);
        clear_counts();
        #2 rst = 1'b0;
        repeat (3) step();
        check("rst_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h0);
        check("rst_time_b", {8'h0, hh_b, mm_b, ss_b}, 32'h0);
        check("rst_flags_a", {27'h0, if_a.set_ack, if_a.set_err, sec_a, min_a, day_a}, 32'h0);
        rst = 1'b1;
        repeat (5) step();

        // Three strobe periods from 00:00:00.
        begin
            int first_lat;
            int total_sec;
            total_sec = 0;
            do_tick();
            first_lat = lat_a;
            total_sec += sec_cnt_a;
            do_tick();
            total_sec += sec_cnt_a;
            do_tick();
            total_sec += sec_cnt_a;
            check("tick_latency", 32'(first_lat), 32'd3);
            check("three_sec_pulses", 32'(total_sec), 32'd3);
            check("three_ticks_a", {8'h0, hh_a, mm_a, ss_a}, 32'h000003);
            check("three_ticks_b", {8'h0, hh_b, mm_b, ss_b}, 32'h000003);
        end

        for (int i = 0; i < 9; i++) begin
            do_set(vecs[i].h, vecs[i].m, vecs[i].s);
            check($sformatf("v%0d_ack_once_a", i), 32'(ack_cnt_a), 32'd1);
            check($sformatf("v%0d_ack_once_b", i), 32'(ack_cnt_b), 32'd1);
            check($sformatf("v%0d_err_a", i), 32'(err_cnt_a), 32'(vecs[i].err_a));
            check($sformatf("v%0d_err_b", i), 32'(err_cnt_b), 32'(vecs[i].err_b));
            check($sformatf("v%0d_stray_err_a", i), 32'(stray_err_a), 32'd0);
            check($sformatf("v%0d_time_a", i), {8'h0, hh_a, mm_a, ss_a}, {8'h0, vecs[i].t_a});
            check($sformatf("v%0d_time_b", i), {8'h0, hh_b, mm_b, ss_b}, {8'h0, vecs[i].t_b});
        end

        // Day rollover on the 24-hour build.
        do_tick();
        check("wrap1_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h235959);
        check("wrap1_time_b", {8'h0, hh_b, mm_b, ss_b}, 32'h000001);
        do_tick();
        check("wrap2_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h000000);
        check("wrap2_pulses_a", {8'h0, 8'(sec_cnt_a), 8'(min_cnt_a), 8'(day_cnt_a)}, 32'h010101);
        check("wrap2_day_aligned_a", 32'(bad_day_a), 32'd0);
        check("wrap2_time_b", {8'h0, hh_b, mm_b, ss_b}, 32'h000002);
        check("wrap2_pulses_b", {8'h0, 8'(sec_cnt_b), 8'(min_cnt_b), 8'(day_cnt_b)}, 32'h010000);

        // Day rollover on the 12-hour build.
        do_set(8'h11, 8'h59, 8'h59);
        check("l11_err", {16'h0, 8'(err_cnt_a), 8'(err_cnt_b)}, 32'h0);
        do_tick();
        check("l11_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h120000);
        check("l11_pulses_a", {8'h0, 8'(sec_cnt_a), 8'(min_cnt_a), 8'(day_cnt_a)}, 32'h010100);
        check("l11_time_b", {8'h0, hh_b, mm_b, ss_b}, 32'h000000);
        check("l11_pulses_b", {8'h0, 8'(sec_cnt_b), 8'(min_cnt_b), 8'(day_cnt_b)}, 32'h010101);

        // Strobe edge timed so its counter update lands on the CHECK cycle.
        clear_counts();
        tick_in = 1'b1;
        step();
        drive_set(1'b1, 8'h12, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 4) tick_in = 1'b0;
        end
        drive_set(1'b0, 8'h12, 8'h00, 8'h00);
        repeat (4) step();
        check("coll_ack_a", 32'(ack_cnt_a), 32'd1);
        check("coll_err_ab", {16'h0, 8'(err_cnt_a), 8'(err_cnt_b)}, 32'h0001);
        check("coll_no_sec_a", 32'(sec_cnt_a), 32'd0);
        check("coll_sec_b", 32'(sec_cnt_b), 32'd1);
        check("coll_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h120000);
        check("coll_time_b", {8'h0, hh_b, mm_b, ss_b}, 32'h000001);
        do_tick();
        check("coll_next_a", {8'h0, hh_a, mm_a, ss_a}, 32'h120001);
        check("coll_next_b", {8'h0, hh_b, mm_b, ss_b}, 32'h000002);

        // Reset while the handshake sits in WAIT_DROP.
        clear_counts();
        drive_set(1'b1, 8'h00, 8'h10, 8'h09);
        repeat (4) step();
        check("pre_rst_ack", 32'(ack_cnt_a), 32'd1);
        check("pre_rst_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h001009);
        #2 rst = 1'b0;
        #1;
        check("async_rst_time_a", {8'h0, hh_a, mm_a, ss_a}, 32'h0);
        check("async_rst_time_b", {8'h0, hh_b, mm_b, ss_b}, 32'h0);
        check("async_rst_flags_a", {27'h0, if_a.set_ack, if_a.set_err, sec_a, min_a, day_a}, 32'h0);
        tick_in = 1'b1;
        drive_set(1'b0, 8'h00, 8'h10, 8'h09);
        repeat (3) step();
        rst = 1'b1;
        clear_counts();
        repeat (10) step();
        check("rel_high_no_tick_a", 32'(sec_cnt_a), 32'd0);
        check("rel_high_no_tick_b", 32'(sec_cnt_b), 32'd0);
        check("rel_no_ack", 32'(ack_cnt_a), 32'd0);
        check("rel_ss_a", 32'(ss_a), 32'h00);
        tick_in = 1'b0;
        repeat (6) step();
        do_tick();
        check("post_rst_tick_a", {8'h0, hh_a, mm_a, ss_a}, 32'h000001);
        check("post_rst_sec_a", 32'(sec_cnt_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
